// File: rtl/set_assoc_cache_if.sv
// rtl/set_assoc_cache_if.sv - CPU-side and physical-memory-side bus bundle for set_assoc_cache
interface set_assoc_cache_if #(
  parameter int LINE_BITS = 128
);
  logic [15:0]          mem_address;
  logic                 mem_read;
  logic                 mem_write;
  logic [1:0]           mem_byte_enable;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;
  logic                 mem_resp;
  logic [15:0]          pmem_address;
  logic                 pmem_read;
  logic                 pmem_write;
  logic [LINE_BITS-1:0] pmem_wdata;
  logic [LINE_BITS-1:0] pmem_rdata;
  logic                 pmem_resp;

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  pmem_rdata, pmem_resp,
    output mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output pmem_rdata, pmem_resp,
    input  mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata
  );
endinterface

// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - N-way set-associative write-back cache with tree pseudo-LRU
// Hits complete combinationally in IDLE; misses run WRITEBACK/ALLOCATE then retry as a hit.
module set_assoc_cache #(
  parameter int WAYS       = 4,
  parameter int SETS       = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  set_assoc_cache_if.slave   bus
);
  localparam int LINE_BITS = 8 * LINE_BYTES;
  localparam int OFF_W     = $clog2(LINE_BYTES);
  localparam int IDX_W     = $clog2(SETS);
  localparam int TAG_W     = 16 - OFF_W - IDX_W;
  localparam int WSEL_W    = OFF_W - 1;
  localparam int BP_W      = $clog2(LINE_BITS);
  localparam int WAY_W     = $clog2(WAYS);
  localparam int NODES     = WAYS - 1;
  localparam int NODE_W    = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int WB_W      = (WAY_W > 1) ? $clog2(WAY_W) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

  logic [TAG_W-1:0]     r_tag   [SETS][WAYS];
  logic [LINE_BITS-1:0] r_data  [SETS][WAYS];
  logic [WAYS-1:0]      r_valid [SETS];
  logic [WAYS-1:0]      r_dirty [SETS];
  logic [NODES-1:0]     r_plru  [SETS];

  state_t               r_state;
  logic [WAY_W-1:0]     r_victim;
  logic [IDX_W-1:0]     r_miss_idx;
  logic [TAG_W-1:0]     r_miss_tag;
  logic [15:0]          r_pmem_address;
  logic                 r_pmem_read;
  logic                 r_pmem_write;

  logic [IDX_W-1:0]     w_idx;
  logic [TAG_W-1:0]     w_tag;
  logic [WSEL_W-1:0]    w_wsel;
  logic [BP_W-1:0]      w_bp_lo;
  logic [BP_W-1:0]      w_bp_hi;
  logic                 w_req;
  logic                 w_hit;
  logic [WAY_W-1:0]     w_hit_way;
  logic                 w_has_inv;
  logic [WAY_W-1:0]     w_inv_way;
  logic [WAY_W-1:0]     w_victim;
  logic                 w_victim_dirty;
  logic [LINE_BITS-1:0] w_hit_line;
  logic [LINE_BITS-1:0] w_merged;
  logic                 w_idle_hit;
  logic                 w_hit_wr;
  logic                 w_fill;
  logic                 w_unused;

  // Heap-ordered tree: node n has children 2n+1 (lower half) and 2n+2 (upper half).
  function automatic logic [WAY_W-1:0] plru_victim(input logic [NODES-1:0] bits);
    int node;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++)
      node = 2 * node + 1 + int'(bits[NODE_W'(node)]);
    return WAY_W'(node - NODES);
  endfunction

  function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                  input logic [WAY_W-1:0] way);
    logic [NODES-1:0] nb;
    logic             b;
    int               node;
    nb   = bits;
    node = 0;
    for (int lvl = 0; lvl < WAY_W; lvl++) begin
      b                 = way[WB_W'(WAY_W - 1 - lvl)];
      nb[NODE_W'(node)] = ~b;
      node              = 2 * node + 1 + int'(b);
    end
    return nb;
  endfunction

  assign w_idx    = bus.mem_address[OFF_W+IDX_W-1:OFF_W];
  assign w_tag    = bus.mem_address[15:OFF_W+IDX_W];
  assign w_wsel   = bus.mem_address[OFF_W-1:1];
  assign w_bp_lo  = {w_wsel, 4'b0000};
  assign w_bp_hi  = {w_wsel, 4'b1000};
  assign w_req    = bus.mem_read | bus.mem_write;
  assign w_unused = bus.mem_address[0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][w] && r_tag[w_idx][w] == w_tag) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins.
  always_comb begin
    w_has_inv = 1'b0;
    w_inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][w]) begin
        w_has_inv = 1'b1;
        w_inv_way = WAY_W'(w);
      end
    end
  end

  assign w_victim       = w_has_inv ? w_inv_way : plru_victim(r_plru[w_idx]);
  assign w_victim_dirty = r_valid[w_idx][w_victim] & r_dirty[w_idx][w_victim];
  assign w_hit_line     = r_data[w_idx][w_hit_way];

  always_comb begin
    w_merged = w_hit_line;
    if (bus.mem_byte_enable[0]) w_merged[w_bp_lo +: 8] = bus.mem_wdata[7:0];
    if (bus.mem_byte_enable[1]) w_merged[w_bp_hi +: 8] = bus.mem_wdata[15:8];
  end

  assign w_idle_hit = (r_state == S_IDLE) && w_req && w_hit;
  assign w_hit_wr   = w_idle_hit && bus.mem_write;
  assign w_fill     = (r_state == S_ALLOCATE) && bus.pmem_resp;

  assign bus.mem_resp     = w_idle_hit;
  assign bus.mem_rdata    = w_idle_hit ? w_hit_line[w_bp_lo +: 16] : 16'h0000;
  assign bus.pmem_address = r_pmem_address;
  assign bus.pmem_read    = r_pmem_read;
  assign bus.pmem_write   = r_pmem_write;
  assign bus.pmem_wdata   = r_pmem_write ? r_data[r_miss_idx][r_victim] : '0;

  always_ff @(posedge clk) begin
    if (w_hit_wr)
      r_data[w_idx][w_hit_way] <= w_merged;
    if (w_fill) begin
      r_data[r_miss_idx][r_victim] <= bus.pmem_rdata;
      r_tag[r_miss_idx][r_victim]  <= r_miss_tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_valid        <= '{default: '0};
      r_dirty        <= '{default: '0};
      r_plru         <= '{default: '0};
      r_victim       <= '0;
      r_miss_idx     <= '0;
      r_miss_tag     <= '0;
      r_pmem_address <= '0;
      r_pmem_read    <= 1'b0;
      r_pmem_write   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req && w_hit) begin
            r_plru[w_idx] <= plru_touch(r_plru[w_idx], w_hit_way);
            if (bus.mem_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
          end else if (w_req) begin
            r_victim   <= w_victim;
            r_miss_idx <= w_idx;
            r_miss_tag <= w_tag;
            if (w_victim_dirty) begin
              r_state        <= S_WRITEBACK;
              r_pmem_write   <= 1'b1;
              r_pmem_address <= {r_tag[w_idx][w_victim], w_idx, {OFF_W{1'b0}}};
            end else begin
              r_state        <= S_ALLOCATE;
              r_pmem_read    <= 1'b1;
              r_pmem_address <= {w_tag, w_idx, {OFF_W{1'b0}}};
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.pmem_resp) begin
            r_state        <= S_ALLOCATE;
            r_pmem_write   <= 1'b0;
            r_pmem_read    <= 1'b1;
            r_pmem_address <= {r_miss_tag, r_miss_idx, {OFF_W{1'b0}}};
          end
        end
        S_ALLOCATE: begin
          if (bus.pmem_resp) begin
            r_state                      <= S_IDLE;
            r_pmem_read                  <= 1'b0;
            r_valid[r_miss_idx][r_victim] <= 1'b1;
            r_dirty[r_miss_idx][r_victim] <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - directed and randomized checks of set_assoc_cache against a cache model
module tb_set_assoc_cache;
  localparam int WAYS = 4, SETS = 8, LB = 16, LINE_BITS = 128;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  set_assoc_cache_if #(.LINE_BITS(LINE_BITS)) bus();
  set_assoc_cache #(.WAYS(WAYS), .SETS(SETS), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory as seen by the responder, and as predicted by the model.
  logic [127:0] pmem_store [int];
  logic [127:0] ref_mem    [int];

  function automatic logic [127:0] init_line(input int la);
    logic [127:0] l;
    for (int w = 0; w < 8; w++) l[w*16 +: 16] = 16'((la * 40503 + w * 4099 + 17) & 16'hFFFF);
    return l;
  endfunction
  function automatic logic [127:0] get_store(input int la);
    return pmem_store.exists(la) ? pmem_store[la] : init_line(la);
  endfunction
  function automatic logic [127:0] get_ref(input int la);
    return ref_mem.exists(la) ? ref_mem[la] : init_line(la);
  endfunction

  typedef struct {bit wr; logic [15:0] a; logic [127:0] d;} ev_t;
  ev_t ev_q[$];

  bit rand_delay = 1'b1;
  int resp_delay = 2;
  bit busy = 1'b0;
  int cnt = 0;
  logic [15:0] cap_addr;
  bit cap_wr;
  int last_resp_cyc = 0;

  // Physical memory responder: fixed or random latency, records every transaction.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy = 1'b0;
      bus.pmem_resp = 1'b0;
    end else if (bus.pmem_resp) begin
      bus.pmem_resp = 1'b0;
      busy = 1'b0;
    end else begin
      if (!busy && (bus.pmem_read || bus.pmem_write)) begin
        busy = 1'b1;
        cap_addr = bus.pmem_address;
        cap_wr = bus.pmem_write;
        cnt = rand_delay ? int'($urandom_range(0, 4)) : resp_delay;
        ev_q.push_back('{bus.pmem_write, bus.pmem_address, bus.pmem_wdata});
      end
      if (busy) begin
        check("pmem_excl", bus.pmem_read & bus.pmem_write, 0);
        check("pmem_addr_stable", bus.pmem_address, cap_addr);
        check("pmem_cmd_stable", {bus.pmem_write, bus.pmem_read}, {cap_wr, ~cap_wr});
        check("no_mem_resp_in_miss", bus.mem_resp, 0);
        if (cnt == 0) begin
          if (cap_wr) pmem_store[int'(cap_addr[15:4])] = bus.pmem_wdata;
          else bus.pmem_rdata = get_store(int'(cap_addr[15:4]));
          bus.pmem_resp = 1'b1;
          last_resp_cyc = cyc + 1;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Behavioural cache model.
  logic [8:0]   m_tag   [SETS][WAYS];
  logic [127:0] m_data  [SETS][WAYS];
  bit           m_val   [SETS][WAYS];
  bit           m_dirty [SETS][WAYS];
  bit           m_plru  [SETS][WAYS-1];

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < WAYS; w++) begin m_val[s][w] = 0; m_dirty[s][w] = 0; end
      for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 0;
    end
  endfunction

  // Range halving: each tree node owns [lo,hi); its bit says which half is older.
  function automatic int model_victim(input int s);
    int lo = 0, hi = WAYS, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (m_plru[s][node]) begin lo = mid; node = 2 * node + 2; end
      else begin hi = mid; node = 2 * node + 1; end
    end
    return lo;
  endfunction

  function automatic void model_touch(input int s, input int way);
    int lo = 0, hi = WAYS, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (way >= mid) begin m_plru[s][node] = 0; lo = mid; node = 2 * node + 2; end
      else begin m_plru[s][node] = 1; hi = mid; node = 2 * node + 1; end
    end
  endfunction

  task automatic access(input logic [15:0] a, input bit wr, input bit both,
                        input logic [1:0] be, input logic [15:0] wd,
                        output bit hit_obs, output logic [15:0] rd);
    int s = int'(a[6:4]);
    int ws = int'(a[3:1]);
    logic [8:0] t = a[15:7];
    logic [15:0] fill_a = {a[15:4], 4'h0};
    int way = -1, vic = -1, start_c = 0, resp_c = 0, n_ev;
    bit wb = 0, got = 0;
    logic [15:0] wb_a = '0;
    logic [127:0] wb_d = '0;
    rd = '0;
    for (int w = 0; w < WAYS; w++) if (m_val[s][w] && m_tag[s][w] == t) way = w;
    if (way < 0) begin
      for (int w = WAYS - 1; w >= 0; w--) if (!m_val[s][w]) vic = w;
      if (vic < 0) vic = model_victim(s);
      wb = m_val[s][vic] && m_dirty[s][vic];
      wb_a = {m_tag[s][vic], 3'(s), 4'h0};
      wb_d = m_data[s][vic];
    end
    ev_q.delete();
    @(negedge clk);
    bus.mem_address = a;
    bus.mem_read = !wr || both;
    bus.mem_write = wr;
    bus.mem_byte_enable = be;
    bus.mem_wdata = wd;
    start_c = cyc;
    for (int n = 0; n < 300; n++) begin
      #1;
      if (bus.mem_resp) begin got = 1; rd = bus.mem_rdata; resp_c = cyc; break; end
      @(negedge clk);
    end
    check("mem_resp_seen", got, 1);
    n_ev = ev_q.size();
    hit_obs = (n_ev == 0);
    if (way < 0) begin
      if (wb) ref_mem[int'(wb_a[15:4])] = wb_d;
      m_data[s][vic] = get_ref(int'(fill_a[15:4]));
      m_tag[s][vic] = t;
      m_val[s][vic] = 1;
      m_dirty[s][vic] = 0;
      check("miss_ev_count", n_ev, wb ? 2 : 1);
      if (n_ev == (wb ? 2 : 1)) begin
        if (wb) check("wb_event", {ev_q[0].wr, ev_q[0].a, ev_q[0].d}, {1'b1, wb_a, wb_d});
        check("fill_event", {ev_q[n_ev-1].wr, ev_q[n_ev-1].a}, {1'b0, fill_a});
      end
      if (got) check("miss_latency", resp_c, last_resp_cyc);
      way = vic;
    end else begin
      check("hit_no_pmem", n_ev, 0);
      if (got) check("hit_same_cycle", resp_c, start_c);
    end
    if (!wr && got) check("rdata", rd, m_data[s][way][ws*16 +: 16]);
    if (wr) begin
      if (be[0]) m_data[s][way][ws*16 +: 8] = wd[7:0];
      if (be[1]) m_data[s][way][ws*16+8 +: 8] = wd[15:8];
      m_dirty[s][way] = 1;
    end
    model_touch(s, way);
    @(posedge clk);
    #1;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_outputs", {bus.pmem_read, bus.pmem_write, bus.mem_resp, bus.pmem_address,
                          bus.mem_rdata}, '0);
    check("rst_pmem_wdata", bus.pmem_wdata, '0);
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  bit h;
  logic [15:0] rd;
  bit seen;

  initial begin
    bus.mem_address = '0; bus.mem_read = 0; bus.mem_write = 0;
    bus.mem_byte_enable = '0; bus.mem_wdata = '0;
    bus.pmem_rdata = '0; bus.pmem_resp = 0;
    model_reset();
    do_reset();

    // Cold read miss with a 3-cycle fill.
    begin
      logic [127:0] l = init_line(16'h123);
      l[2*16 +: 16] = 16'hBEEF;
      pmem_store[16'h123] = l;
      ref_mem[16'h123] = l;
    end
    rand_delay = 0; resp_delay = 3;
    access(16'h1234, 0, 0, 2'b00, 16'h0, h, rd);
    check("t1_miss", h, 0);
    check("t1_rdata", rd, 16'hBEEF);
    check("t1_no_writeback", (ev_q.size() > 0) ? ev_q[0].wr : 1'b1, 0);

    // Byte-masked write hit then read back.
    access(16'h1234, 1, 0, 2'b01, 16'hAA55, h, rd);
    check("t2_write_hit", h, 1);
    access(16'h1234, 0, 0, 2'b00, 16'h0, h, rd);
    check("t2_rdata", rd, 16'hBE55);

    // Fill a set, then evict the PLRU way.
    rand_delay = 1;
    do_reset();
    access(16'h0030, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h00B0, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h0130, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h01B0, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h0030, 0, 0, 2'b00, 16'h0, h, rd);
    check("t3_reread_hit", h, 1);
    access(16'h0230, 0, 0, 2'b00, 16'h0, h, rd);
    check("t3_evict_miss", h, 0);
    check("t3_clean_evict", ev_q.size(), 1);
    access(16'h0130, 0, 0, 2'b00, 16'h0, h, rd);
    check("t3_victim_was_way2", h, 0);
    access(16'h0030, 0, 0, 2'b00, 16'h0, h, rd);
    check("t3_way0_kept", h, 1);

    // Dirty eviction goes through writeback.
    do_reset();
    access(16'h0030, 1, 0, 2'b11, 16'h1111, h, rd);
    access(16'h00B0, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h0130, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h01B0, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h0230, 0, 0, 2'b00, 16'h0, h, rd);
    check("t4_ev_count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("t4_wb_addr", {ev_q[0].wr, ev_q[0].a}, {1'b1, 16'h0030});
      check("t4_wb_word0", ev_q[0].d[15:0], 16'h1111);
      check("t4_fill_addr", {ev_q[1].wr, ev_q[1].a}, {1'b0, 16'h0230});
    end

    // Long fill: responder checks stability each waiting cycle.
    rand_delay = 0; resp_delay = 10;
    access(16'h0430, 0, 0, 2'b00, 16'h0, h, rd);
    check("t5_long_miss", h, 0);

    // Reset in the middle of a writeback.
    do_reset();
    rand_delay = 1;
    access(16'h0030, 1, 0, 2'b11, 16'h1111, h, rd);
    access(16'h00B0, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h0130, 0, 0, 2'b00, 16'h0, h, rd);
    access(16'h01B0, 0, 0, 2'b00, 16'h0, h, rd);
    rand_delay = 0; resp_delay = 50;
    @(negedge clk);
    bus.mem_address = 16'h0230; bus.mem_read = 1'b1;
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk); #1;
      if (bus.pmem_write) begin seen = 1; break; end
    end
    check("t6_wb_started", seen, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop", {bus.pmem_write, bus.pmem_read}, 2'b00);
    bus.mem_read = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    rand_delay = 1;
    access(16'h0030, 0, 0, 2'b00, 16'h0, h, rd);
    check("t6_miss_after_reset", h, 0);
    check("t6_no_writeback", ev_q.size(), 1);

    // Randomized traffic over two sets with more tags than ways.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [15:0] a;
      bit wr;
      a = {9'($urandom_range(0, 5)), 3'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'b0};
      wr = ($urandom_range(0, 2) == 0);
      access(a, wr, ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
             16'($urandom), h, rd);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
